// File: rtl/pwm_dac_multi.sv
// pwm_dac_multi: NCH-channel dithered PWM DAC with a small register bus for manual values.
// Latency: pwm_o is registered one cycle after the counter compare; bus ack/rdata one cycle after the strobe.
// Backpressure: none; every bus strobe is acknowledged exactly one cycle later and never stalls.
module pwm_dac_multi #(
  parameter int NCH = 4,
  parameter int DW  = 14,
  parameter int PW  = 8,
  parameter int SW  = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [NCH*DW-1:0] pwm_i,
  output logic [NCH-1:0]    pwm_o,
  input  logic [31:0]       sys_addr,
  input  logic [31:0]       sys_wdata,
  input  logic              sys_wen,
  input  logic              sys_ren,
  output logic [31:0]       sys_rdata,
  output logic              sys_ack,
  output logic              sys_err
);

  logic [PW-1:0]          r_cnt;
  logic [SW-1:0]          r_ph;
  logic [NCH-1:0][PW:0]   r_thr;
  logic [NCH-1:0]         r_pwm;
  logic [NCH-1:0][DW-1:0] r_man;
  logic [NCH-1:0]         r_src;
  logic                   r_ack;
  logic [31:0]            r_rdata;

  logic                   w_wrap;
  logic [SW-1:0]          w_ph_nxt;
  logic [SW-1:0]          w_ph_rev;
  logic [NCH-1:0][PW:0]   w_thr_nxt;
  logic [19:0]            w_addr;
  logic [31:0]            w_rd;
  logic                   w_unused;

  assign w_addr   = sys_addr[19:0];
  assign w_wrap   = (r_cnt == {PW{1'b1}});
  assign w_ph_nxt = r_ph + SW'(1);
  assign w_unused = ^{sys_addr[31:20], sys_wdata};

  // Dither slot order: bit-reversed phase of the period that is about to start
  always_comb begin
    w_ph_rev = '0;
    for (int i = 0; i < SW; i++) begin
      w_ph_rev[i] = w_ph_nxt[SW-1-i];
    end
  end

  // Per channel: pick source, offset-binary convert, split into duty and dither fraction
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DW-1:0] w_smp;
    logic [DW-1:0] w_u;
    logic [PW-1:0] w_duty;
    logic [SW-1:0] w_frac;
    logic          w_extra;
    logic          w_unused;

    assign w_smp        = r_src[k] ? pwm_i[k*DW +: DW] : r_man[k];
    assign w_u          = {~w_smp[DW-1], w_smp[DW-2:0]};
    assign w_duty       = w_u[DW-1 -: PW];
    assign w_frac       = w_u[DW-PW-1 -: SW];
    assign w_extra      = (w_ph_rev < w_frac);
    assign w_thr_nxt[k] = {1'b0, w_duty} + {{PW{1'b0}}, w_extra};
    // Low sample bits below the dither fraction are intentionally dropped
    assign w_unused     = ^w_u;
  end

  // Free-running period counter and dither phase that steps once per period
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
      r_ph  <= '0;
    end else begin
      r_cnt <= r_cnt + PW'(1);
      if (w_wrap) begin
        r_ph <= w_ph_nxt;
      end
    end
  end

  // Thresholds reload only on the last cycle of a period; outputs compare against the live threshold
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_thr <= '0;
      r_pwm <= '0;
    end else begin
      if (w_wrap) begin
        r_thr <= w_thr_nxt;
      end
      for (int k = 0; k < NCH; k++) begin
        r_pwm[k] <= ({1'b0, r_cnt} < r_thr[k]);
      end
    end
  end

  // Writable registers: manual sample values and source select
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_man <= '0;
      r_src <= '1;
    end else if (sys_wen) begin
      for (int k = 0; k < NCH; k++) begin
        if (w_addr == 20'(4 * k)) begin
          r_man[k] <= sys_wdata[DW-1:0];
        end
      end
      if (w_addr == 20'h40) begin
        r_src <= sys_wdata[NCH-1:0];
      end
    end
  end

  // Read mux over the register map; unmapped addresses read as zero
  always_comb begin
    w_rd = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_addr == 20'(4 * k)) begin
        w_rd[DW-1:0] = r_man[k];
      end
      if (w_addr == 20'(72 + 4 * k)) begin
        w_rd[PW:0] = r_thr[k];
      end
    end
    if (w_addr == 20'h40) begin
      w_rd[NCH-1:0] = r_src;
    end
    if (w_addr == 20'h44) begin
      w_rd[PW+SW-1:0] = {r_ph, r_cnt};
    end
  end

  // Single-cycle acknowledge; read data captured pre-write so a combined wen/ren returns prior contents
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= sys_wen | sys_ren;
      r_rdata <= sys_ren ? w_rd : 32'h0;
    end
  end

  assign pwm_o     = r_pwm;
  assign sys_ack   = r_ack;
  assign sys_rdata = r_rdata;
  assign sys_err   = 1'b0;

endmodule

// File: tb/tb_pwm_dac_multi.sv
// tb_pwm_dac_multi: randomized and directed bench for pwm_dac_multi against an arithmetic model.
// Time base is cycles since reset release; per-period high counts are gathered on every falling edge.
// Bus accesses are two cycles each: strobe cycle, then ack/rdata check cycle.
module tb_pwm_dac_multi;
  localparam int NCH  = 4;
  localparam int DW   = 14;
  localparam int PW   = 8;
  localparam int SW   = 4;
  localparam int PER  = 1 << PW;
  localparam int NPER = 17;

  logic              clk_i;
  logic              rstn_i;
  logic [NCH*DW-1:0] pwm_i;
  logic [NCH-1:0]    pwm_o;
  logic [31:0]       sys_addr;
  logic [31:0]       sys_wdata;
  logic              sys_wen;
  logic              sys_ren;
  logic [31:0]       sys_rdata;
  logic              sys_ack;
  logic              sys_err;

  int          n_tests;
  int          n_fail;
  int          cyc;
  int          hi [0:NPER-1][0:NCH-1];
  int          smp [0:NCH-1];
  logic [31:0] d;
  logic [31:0] rnd;
  int          at;

  pwm_dac_multi #(.NCH(NCH), .DW(DW), .PW(PW), .SW(SW)) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .pwm_i     (pwm_i),
    .pwm_o     (pwm_o),
    .sys_addr  (sys_addr),
    .sys_wdata (sys_wdata),
    .sys_wen   (sys_wen),
    .sys_ren   (sys_ren),
    .sys_rdata (sys_rdata),
    .sys_ack   (sys_ack),
    .sys_err   (sys_err)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: threshold in force during period p after reset, from the sample's arithmetic value
  function automatic int exp_thr(input int s, input int p);
    int u;
    int duty;
    int frac;
    int ph;
    int r;
    if (p == 0) return 0;
    u    = s + (1 << (DW - 1));
    duty = u / (1 << (DW - PW));
    frac = (u % (1 << (DW - PW))) / (1 << (DW - PW - SW));
    ph   = p % (1 << SW);
    r    = 0;
    for (int i = 0; i < SW; i++) r = r * 2 + ((ph >> i) & 1);
    return duty + ((r < frac) ? 1 : 0);
  endfunction

  task automatic clear_hi();
    for (int p = 0; p < NPER; p++)
      for (int k = 0; k < NCH; k++) hi[p][k] = 0;
  endtask

  // One cycle; output seen at the falling edge of cycle n reflects the compare of cycle n-1
  task automatic tick();
    @(negedge clk_i);
    cyc++;
    if ((cyc - 1) / PER < NPER)
      for (int k = 0; k < NCH; k++) hi[(cyc - 1) / PER][k] += int'(pwm_o[k]);
  endtask

  task automatic do_reset(input int n);
    rstn_i  = 1'b0;
    sys_wen = 1'b0;
    sys_ren = 1'b0;
    repeat (n) @(negedge clk_i);
    rstn_i = 1'b1;
    cyc    = 0;
    clear_hi();
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] v);
    sys_addr  = a;
    sys_wdata = v;
    sys_wen   = 1'b1;
    tick();
    sys_wen = 1'b0;
    chk("wr_ack", 32'(sys_ack), 32'd1);
    tick();
    chk("wr_ack_1cyc", 32'(sys_ack), 32'd0);
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
    sys_addr = a;
    sys_ren  = 1'b1;
    tick();
    sys_ren = 1'b0;
    chk("rd_ack", 32'(sys_ack), 32'd1);
    v = sys_rdata;
    tick();
    chk("rd_ack_1cyc", 32'(sys_ack), 32'd0);
  endtask

  initial begin
    int dir [0:4];
    dir = '{-8192, 0, 4, 32, 8191};
    rstn_i    = 1'b0;
    pwm_i     = '0;
    sys_addr  = '0;
    sys_wdata = '0;
    sys_wen   = 1'b0;
    sys_ren   = 1'b0;
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    clear_hi();

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_pwm_o", 32'(pwm_o), 32'd0);
    chk("rst_ack", 32'(sys_ack), 32'd0);
    chk("rst_rdata", sys_rdata, 32'd0);
    chk("sys_err", 32'(sys_err), 32'd0);
    rstn_i = 1'b1;
    cyc    = 0;
    clear_hi();
    bus_rd(32'h40, d); chk("rst_src_sel", d, 32'hF);
    bus_rd(32'h00, d); chk("rst_man0", d, 32'd0);
    bus_rd(32'h48, d); chk("rst_thr0", d, 32'd0);
    at = cyc;
    bus_rd(32'h44, d); chk("cnt_after_rel", d, 32'(at));

    // Period-by-period high counts: directed ch0 values, then fully random vectors
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NCH; k++) smp[k] = int'($urandom_range(0, 16383)) - 8192;
      if (r < 5) smp[0] = dir[r];
      for (int k = 0; k < NCH; k++) pwm_i[k*DW +: DW] = smp[k][DW-1:0];
      do_reset(2);
      repeat (NPER * PER) tick();
      for (int p = 0; p < NPER; p++)
        for (int k = 0; k < NCH; k++)
          chk($sformatf("v%0d_p%0d_ch%0d", r, p, k), 32'(hi[p][k]), 32'(exp_thr(smp[k], p)));
    end

    // Manual source, mid-period write, boundary-aligned threshold update
    pwm_i = 56'($urandom()) ^ {$urandom(), $urandom()};
    do_reset(1);
    bus_wr(32'h40, 32'h0);
    while (cyc < 300) tick();
    bus_rd(32'h4C, d); chk("thr1_first", d, 32'd128);
    while (cyc < 400) tick();
    bus_wr(32'h04, 32'h1000);
    bus_rd(32'h04, d); chk("man1_rb", d, 32'h1000);
    bus_rd(32'h4C, d); chk("thr1_hold", d, 32'd128);
    while (cyc < 520) tick();
    bus_rd(32'h4C, d); chk("thr1_next", d, 32'd192);

    // Combined write+read: write wins, read returns prior contents
    rnd       = $urandom();
    sys_addr  = 32'h08;
    sys_wdata = rnd;
    sys_wen   = 1'b1;
    sys_ren   = 1'b1;
    tick();
    sys_wen = 1'b0;
    sys_ren = 1'b0;
    chk("wr_rd_ack", 32'(sys_ack), 32'd1);
    chk("wr_rd_prior", sys_rdata, 32'd0);
    tick();
    chk("wr_rd_1ack", 32'(sys_ack), 32'd0);
    bus_rd(32'h08, d); chk("man2_rb", d, rnd & 32'h3FFF);
    bus_wr(32'h0C, 32'hFFFF_FFFF);
    bus_rd(32'h1000_000C, d); chk("man3_upper0", d, 32'h3FFF);
    bus_rd(32'h100, d); chk("unmapped_rd", d, 32'd0);
    bus_wr(32'h4C, 32'h0);
    bus_rd(32'h4C, d); chk("thr_ro", d, 32'd192);
    bus_wr(32'h200, 32'h5);
    bus_rd(32'h40, d); chk("src_after_unmapped", d, 32'd0);
    while (cyc < 800) tick();
    chk("ch1_p0", 32'(hi[0][1]), 32'd0);
    chk("ch1_p1_unchanged", 32'(hi[1][1]), 32'd128);
    chk("ch1_p2_new", 32'(hi[2][1]), 32'd192);
    chk("ch0_p2", 32'(hi[2][0]), 32'd128);

    // One-cycle reset mid-period, with a read strobe that reset must swallow
    while (cyc < 900) tick();
    rstn_i   = 1'b0;
    sys_addr = 32'h40;
    sys_ren  = 1'b1;
    @(negedge clk_i);
    sys_ren = 1'b0;
    chk("mid_rst_pwm_o", 32'(pwm_o), 32'd0);
    chk("mid_rst_ack", 32'(sys_ack), 32'd0);
    chk("mid_rst_rdata", sys_rdata, 32'd0);
    rstn_i = 1'b1;
    cyc    = 0;
    clear_hi();
    bus_rd(32'h44, d); chk("mid_rst_cnt0", d, 32'd0);
    bus_rd(32'h40, d); chk("mid_rst_src", d, 32'hF);
    bus_rd(32'h04, d); chk("mid_rst_man1", d, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_dac_multi.md
PWM_DAC_MULTI -- requirements
Module: pwm_dac_multi

Interface
REQ-001 SHALL have parameter NCH, default 4: number of PWM channels.
REQ-002 SHALL have parameter DW, default 14: width of each signed sample input.
REQ-003 SHALL have parameter PW, default 8: PWM counter bits, giving a 2^PW-cycle period.
REQ-004 SHALL have parameter SW, default 4: dither bits, giving a 2^SW-period dither sequence; PW+SW <= DW.
REQ-005 SHALL have port clk_i, input, 1 bit: clock, all logic on rising edge.
REQ-006 SHALL have port rstn_i, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port pwm_i, input, NCH*DW bits: signed two's-complement samples, channel k at [k*DW +: DW].
REQ-008 SHALL have port pwm_o, output, NCH bits: registered PWM outputs.
REQ-009 SHALL have port sys_addr, input, 32 bits: bus address, decoded on [19:0].
REQ-010 SHALL have port sys_wdata, input, 32 bits: bus write data.
REQ-011 SHALL have port sys_wen, input, 1 bit: write strobe, one cycle.
REQ-012 SHALL have port sys_ren, input, 1 bit: read strobe, one cycle.
REQ-013 SHALL have port sys_rdata, output, 32 bits: read data.
REQ-014 SHALL have port sys_ack, output, 1 bit: acknowledge.
REQ-015 SHALL have port sys_err, output, 1 bit: error, tied 0.

Function
REQ-016 SHALL run a free-running PW-bit counter cnt, +1 per cycle, wrapping 2^PW-1 -> 0.
REQ-017 SHALL run an SW-bit phase counter ph, +1 on each cnt wrap, itself wrapping 2^SW-1 -> 0.
REQ-018 SHALL select each channel's source from src_sel[k]: 1 = pwm_i channel k, 0 = register man_val[k] (signed DW bits).
REQ-019 SHALL convert the selected sample to unsigned u by inverting its MSB, so min-negative -> 0 and max-positive -> 2^DW-1.
REQ-020 SHALL take duty = u[DW-1 -: PW] and frac = u[DW-PW-1 -: SW]; lower bits are discarded.
REQ-021 SHALL compute extra = 1 when bitreverse(ph) < frac, else 0; frac=2^(SW-1) therefore alternates every period.
REQ-022 SHALL latch thr[k] = duty + extra, PW+1 bits, only on the cycle cnt == 2^PW-1, so thresholds change only at period boundaries.
REQ-023 SHALL register pwm_o[k] = (cnt < thr[k]) with one cycle of output latency; thr = 0 gives constant low and thr = 2^PW gives constant high.
REQ-024 SHALL provide register map 0x00 + 4*k (k < NCH): man_val[k], read/write, DW bits, upper bits read 0.
REQ-025 SHALL provide register 0x40: src_sel, read/write, NCH bits.
REQ-026 SHALL provide register 0x44: read-only {ph, cnt}, zero-extended.
REQ-027 SHALL provide register 0x48 + 4*k: read-only thr[k], zero-extended.
REQ-028 SHALL assert sys_ack for exactly one cycle, the cycle after sys_wen or sys_ren; sys_rdata SHALL be valid in that same cycle.
REQ-029 SHALL return rdata 0 and still acknowledge for unmapped addresses; writes to unmapped or read-only addresses SHALL be ignored.
REQ-030 SHALL give priority to sys_wen when sys_wen and sys_ren are asserted together: write performed, rdata = prior contents, single ack.
REQ-031 SHALL make a register write take effect in thr at the next period boundary, never mid-period.

Reset
REQ-032 SHALL, with rstn_i low at a clock edge, clear cnt, ph, thr, pwm_o, sys_ack and sys_rdata to 0, set man_val to 0, and set src_sel to all ones.
REQ-033 SHALL abandon any in-progress period and bus access on reset; after release the first period SHALL output low until the first boundary latch (thr = 0).
REQ-034 SHALL, on release, start cnt at 0 on the first cycle with rstn_i high.

Verification
REQ-035 SHALL be verified for: pwm_i ch0 = -8192 (DW=14, PW=8, SW=4) -> pwm_o[0] low for all 16 periods.
REQ-036 SHALL be verified for: pwm_i ch0 = 0 -> exactly 128 high cycles per 256-cycle period, all periods identical.
REQ-037 SHALL be verified for: pwm_i ch0 = 4 (frac=1) -> 129 high cycles in the period where ph=0, 128 in the other 15; pwm_i = 32 (frac=8) -> 129/128 alternating.
REQ-038 SHALL be verified for: pwm_i ch0 = 8191 -> 15 of 16 periods fully high (256), one period with 255 high.
REQ-039 SHALL be verified for: write src_sel=0 then man_val[1]=0x1000 mid-period -> ack one cycle later, readback 0x1000, thr[1]=192 from the next boundary, current period unchanged.
REQ-040 SHALL be verified for: rstn_i low for one cycle mid-period -> all outputs 0 next cycle, src_sel reads 0xF, cnt restarts at 0.
